// File: rtl/float_out_fifo.sv
// float_out_fifo: decimates a float result stream, converts each kept sample to
// saturating signed Q1.(OUT_W-1) fixed point and buffers it in a small FIFO.
module float_out_fifo #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23,
    parameter int OSR    = 1,
    parameter int OUT_W  = 16,
    parameter int DEPTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [EXP_W+MANT_W:0]     in,
    output logic [OUT_W-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      sat,
    output logic                      ovf,
    output logic [$clog2(DEPTH):0]    level
);
    localparam int AW   = $clog2(DEPTH);
    localparam int PW   = (OSR > 1) ? $clog2(OSR) : 1;
    localparam int BIAS = 2 ** (EXP_W - 1) - 1;

    logic [PW-1:0]             phase_q, phase_d;
    logic [EXP_W+MANT_W:0]     s1_q;
    logic                      s1_v_q;
    logic [OUT_W-1:0]          cv_q, cv_d;
    logic                      cv_v_q, cv_sat_q, cv_sat_d;
    logic [OUT_W-1:0]          mem [DEPTH];
    logic [AW-1:0]             wp_q, rp_q;
    logic [AW:0]               lvl_q, lvl_d;
    logic                      sat_q, ovf_q;
    logic                      sgn, full, push, pop, wr;
    logic [EXP_W-1:0]          e;
    logic [31:0]               rsh;
    logic [MANT_W+OUT_W-1:0]   wide;

    assign sgn = s1_q[EXP_W+MANT_W];
    assign e   = s1_q[EXP_W+MANT_W-1:MANT_W];
    // Align 1.m so that the integer part of the shifted value is the truncated magnitude
    assign rsh  = 32'(MANT_W + BIAS) - 32'(e);
    assign wide = {1'b1, s1_q[MANT_W-1:0], {(OUT_W-1){1'b0}}} >> rsh;

    always_comb begin
        phase_d  = (phase_q == PW'(OSR - 1)) ? '0 : phase_q + 1'b1;
        cv_sat_d = (e >= EXP_W'(BIAS));
        cv_d     = (e == '0) ? '0 :
                   cv_sat_d  ? {sgn, {(OUT_W-1){~sgn}}} :
                   sgn       ? -wide[OUT_W-1:0] : wide[OUT_W-1:0];
    end

    assign full      = (lvl_q == (AW+1)'(DEPTH));
    assign out_valid = (lvl_q != '0);
    assign pop       = out_valid & out_ready;
    assign push      = cv_v_q;
    assign wr        = push & (~full | pop);
    assign lvl_d     = lvl_q + (AW+1)'(wr) - (AW+1)'(pop);
    assign out_data  = mem[rp_q];
    assign level     = lvl_q;
    assign sat       = sat_q;
    assign ovf       = ovf_q;

    always_ff @(posedge clk) begin
        if (wr) mem[wp_q] <= cv_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q  <= '0;
            s1_q     <= '0;
            s1_v_q   <= 1'b0;
            cv_q     <= '0;
            cv_v_q   <= 1'b0;
            cv_sat_q <= 1'b0;
            wp_q     <= '0;
            rp_q     <= '0;
            lvl_q    <= '0;
            sat_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            s1_q     <= in;
            s1_v_q   <= (phase_q == '0);
            cv_q     <= cv_d;
            cv_v_q   <= s1_v_q;
            cv_sat_q <= cv_sat_d & s1_v_q;
            wp_q     <= wp_q + AW'(wr);
            rp_q     <= rp_q + AW'(pop);
            lvl_q    <= lvl_d;
            sat_q    <= sat_q | (cv_v_q & cv_sat_q);
            ovf_q    <= ovf_q | (push & full & ~pop);
        end
    end
endmodule

// File: tb/tb_float_out_fifo.sv
// tb_float_out_fifo: directed vectors for conversion, decimation, FIFO flow control and reset.
module tb_float_out_fifo;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] in1 = '0, in4 = '0;
    logic        rdy1 = 1'b0, rdy4 = 1'b0;
    logic [15:0] d1, d4;
    logic        v1, v4, sat1, sat4, ovf1, ovf4;
    logic [3:0]  lvl1, lvl4;
    int          total = 0, bad = 0;

    typedef struct {
        logic [31:0] in;
        logic [15:0] out;
        logic        sat;
    } vec_t;
    vec_t vt[16];

    float_out_fifo #(.OSR(1)) dut (
        .clk(clk), .rst(rst), .in(in1), .out_data(d1), .out_valid(v1),
        .out_ready(rdy1), .sat(sat1), .ovf(ovf1), .level(lvl1)
    );
    float_out_fifo #(.OSR(4)) dut4 (
        .clk(clk), .rst(rst), .in(in4), .out_data(d4), .out_valid(v4),
        .out_ready(rdy4), .sat(sat4), .ovf(ovf4), .level(lvl4)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
    endtask

    // exact float encoding of k/64 for 0 <= k < 16
    function automatic logic [31:0] fk(input int k);
        int p;
        p = 0;
        if (k == 0) return 32'h0;
        for (int i = 0; i < 5; i++) if (((k >> i) & 1) == 1) p = i;
        return {1'b0, 8'(127 + p - 6), 23'((k - (1 << p)) << (23 - p))};
    endfunction

    initial begin
        logic [15:0] q[$];
        vt[0]  = '{32'h3F000000, 16'h4000, 1'b0};
        vt[1]  = '{32'hBE800000, 16'hE000, 1'b0};
        vt[2]  = '{32'h00000000, 16'h0000, 1'b0};
        vt[3]  = '{32'h80000000, 16'h0000, 1'b0};
        vt[4]  = '{32'h00400000, 16'h0000, 1'b0};
        vt[5]  = '{32'h38000000, 16'h0001, 1'b0};
        vt[6]  = '{32'hB8000000, 16'hFFFF, 1'b0};
        vt[7]  = '{32'h37800000, 16'h0000, 1'b0};
        vt[8]  = '{32'h3EC00000, 16'h3000, 1'b0};
        vt[9]  = '{32'h3F7FFFFF, 16'h7FFF, 1'b0};
        vt[10] = '{32'hBF7FFFFF, 16'h8001, 1'b0};
        vt[11] = '{32'h3F800000, 16'h7FFF, 1'b1};
        vt[12] = '{32'hC0000000, 16'h8000, 1'b1};
        vt[13] = '{32'h7F800000, 16'h7FFF, 1'b1};
        vt[14] = '{32'hFF800000, 16'h8000, 1'b1};
        vt[15] = '{32'h3E000000, 16'h1000, 1'b1};

        #2;
        check("rst_valid", 32'(v1), 0);
        check("rst_level", 32'(lvl1), 0);
        check("rst_sat", 32'(sat1), 0);
        check("rst_ovf", 32'(ovf1), 0);
        do_reset();

        // streaming conversion: head after edge n+1 holds vector n-2
        rdy1 = 1'b1;
        for (int n = 0; n < 18; n++) begin
            in1 = (n < 16) ? vt[n].in : 32'h0;
            tick();
            if (n < 2) check("conv_early_valid", 32'(v1), 0);
            else begin
                check("conv_valid", 32'(v1), 1);
                check($sformatf("conv_data[%0d]", n - 2), 32'(d1), 32'(vt[n-2].out));
                check($sformatf("conv_sat[%0d]", n - 2), 32'(sat1), 32'(vt[n-2].sat));
                check("conv_level", 32'(lvl1), 1);
            end
        end

        // decimation by 4: only k = 0,4,8,12 survive
        do_reset();
        rdy4 = 1'b1;
        for (int k = 0; k < 18; k++) begin
            in4 = (k < 16) ? fk(k) : fk(5);
            tick();
            if (v4) q.push_back(d4);
        end
        check("dec_count", 32'(q.size()), 4);
        for (int i = 0; i < 4 && i < q.size(); i++)
            check($sformatf("dec_data[%0d]", i), 32'(q[i]), 32'(i * 16'h0800));

        // full FIFO with simultaneous push and pop
        do_reset();
        rdy1 = 1'b0;
        for (int n = 1; n <= 18; n++) begin
            in1  = fk(n <= 15 ? n : 15);
            rdy1 = (n >= 11);
            tick();
            if (n >= 10) begin
                check("fp_level", 32'(lvl1), 8);
                check("fp_ovf", 32'(ovf1), 0);
                check("fp_data", 32'(d1), 32'((n - 9) << 9));
            end
        end

        // backpressure overflow: 10 pushes into 8 entries
        do_reset();
        rdy1 = 1'b0;
        for (int n = 1; n <= 14; n++) begin
            in1 = (n <= 10) ? fk(n) : 32'h0;
            tick();
        end
        check("bp_level", 32'(lvl1), 8);
        check("bp_ovf", 32'(ovf1), 1);
        rdy1 = 1'b1;
        for (int j = 0; j < 9; j++) begin
            check("bp_valid", 32'(v1), 1);
            check($sformatf("bp_data[%0d]", j), 32'(d1), (j < 8) ? 32'((j + 1) << 9) : 32'h0);
            tick();
        end
        check("bp_ovf_sticky", 32'(ovf1), 1);

        // asynchronous reset mid-stream with level 5
        do_reset();
        rdy1 = 1'b0;
        for (int n = 1; n <= 7; n++) begin
            in1 = (n == 1) ? 32'h3F800000 : fk(n);
            tick();
        end
        check("mr_level_pre", 32'(lvl1), 5);
        check("mr_sat_pre", 32'(sat1), 1);
        #2 rst = 1'b0;
        #1;
        check("mr_valid", 32'(v1), 0);
        check("mr_level", 32'(lvl1), 0);
        check("mr_sat", 32'(sat1), 0);
        tick();
        tick();
        rst  = 1'b1;
        rdy1 = 1'b1;
        in1  = fk(9);
        tick();
        in1  = fk(3);
        tick();
        check("mr_early_valid", 32'(v1), 0);
        tick();
        check("mr_first_valid", 32'(v1), 1);
        check("mr_first_data", 32'(d1), 32'h1200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/float_out_fifo.md
FLOAT_OUT_FIFO -- requirements
Module: float_out_fifo

Interface
REQ-001 Parameter EXP_W, default 8: exponent width of the incoming floatType word.
REQ-002 Parameter MANT_W, default 23: mantissa width of the incoming floatType word, with an implicit leading 1.
REQ-003 Parameter OSR, default 1: decimation factor; one result in every OSR is kept.
REQ-004 Parameter OUT_W, default 16: width of the signed fixed-point output.
REQ-005 Parameter DEPTH, default 8: output FIFO entries; power of two, at least 2.
REQ-006 clk  in  1  single system clock; all state changes on its rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 in  in  1+EXP_W+MANT_W  filter result from the batch top; sign bit is the MSB, then exponent, then mantissa; a new value arrives every clk.
REQ-009 out_data  out  OUT_W  signed fixed-point sample, Q1.(OUT_W-1), taken from the FIFO head.
REQ-010 out_valid  out  1  FIFO is non-empty and out_data is valid.
REQ-011 out_ready  in  1  consumer accepts the head entry.
REQ-012 sat  out  1  sticky flag: at least one conversion has saturated since reset.
REQ-013 ovf  out  1  sticky flag: at least one sample was dropped because the FIFO was full.
REQ-014 level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-015 Decimation:
- A phase counter counts 0..OSR-1 and wraps to 0.
- It is 0 in the first cycle after rst deasserts.
- in is captured into stage 1 only on edges where phase==0.
REQ-016 Conversion (stage 2): let bias=2^(EXP_W-1)-1 and value=(-1)^s * 1.m * 2^(e-bias); the result is value*2^(OUT_W-1) with the magnitude truncated toward zero.
REQ-017 Exponent field 0 (zero or denormal) SHALL convert to 0, with no saturation.
REQ-018 Saturation cases:
- A magnitude of 2^(OUT_W-1) or more, or an exponent field of all-ones, SHALL saturate.
- Positive values go to 2^(OUT_W-1)-1; negative values go to -2^(OUT_W-1).
- sat is set the cycle after the saturating conversion is registered.
REQ-019 A -0 input (sign=1, zero magnitude) SHALL output 0.
REQ-020 Latency and FIFO write:
- A value captured at edge k is converted at edge k+1 and written to the FIFO at edge k+2.
- out_valid is high after edge k+2 if the FIFO was empty.
REQ-021 Pop occurs on an edge where out_valid && out_ready; out_data is the combinational read of the head entry.
REQ-022 Push while full with no simultaneous pop SHALL drop the new sample, leave the FIFO unchanged and set ovf.
REQ-023 Push and pop on the same edge when full SHALL accept both; level stays at DEPTH and ovf is not set.
REQ-024 Push and pop on the same edge when empty: the push is accepted and no pop occurs (out_valid was low); level becomes 1.
REQ-025 Read and write pointers wrap modulo DEPTH; level is always the number of writes minus the number of reads, within 0..DEPTH.
REQ-026 out_data is unspecified while out_valid is low; the bench SHALL NOT check it then.
REQ-027 sat and ovf are cleared only by reset.

Reset
REQ-028 While rst is low, all of the following hold:
- Pointers, level, phase counter and the pipeline valid bits are 0.
- out_valid, sat and ovf are 0.
REQ-029 Reset asserted mid-operation SHALL take effect immediately, discarding the FIFO contents and all in-flight pipeline samples.
REQ-030 After release, the first capture occurs on the first rising edge with rst high.

Verification
REQ-031 Basic conversion (OSR=1, out_ready=1): in = 0x3F000000 (0.5), then 0xBE800000 (-0.25), then 0x00000000 -> out_data = 0x4000, 0xE000, 0x0000 on consecutive cycles, the first at edge 3 after release; sat = 0.
REQ-032 Saturation: in = 0x3F800000 (1.0) -> out_data = 0x7FFF, sat = 1; in = 0xC0000000 (-2.0) -> out_data = 0x8000; in = 0x7F800000 -> out_data = 0x7FFF.
REQ-033 Decimation (OSR=4): in ramps k/64 (exact float encodings) for k = 0..15 -> exactly 4 outputs, equal to the k = 0, 4, 8, 12 values (0x0000, 0x0800, 0x1000, 0x1800).
REQ-034 Backpressure (DEPTH=8, out_ready=0, OSR=1): 10 pushes -> level = 8 and ovf = 1; then out_ready=1 -> the first 8 samples are popped in order and the last 2 are absent.
REQ-035 Full plus simultaneous pop: FIFO full with out_ready=1 and a continuous push -> level stays at 8 every cycle and ovf stays 0.
REQ-036 Reset mid-stream: rst pulled low with level = 5 -> out_valid = 0 and level = 0 asynchronously; the first output after release is the first sample captured after release.
